// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: control, instruction-RAM and datapath signals of the fetch sequencer.
interface fetch_sequencer_if;
  logic start;
  logic abort;
  logic [8:0] instr_addr;
  logic [15:0] instr_in;
  logic [15:0] ir;
  logic ir_valid;
  logic exec_done;
  logic z_flag;
  logic [8:0] pc;
  logic busy;
  logic halted;
  logic err;
  logic [15:0] instr_count;
  modport master (
    input start, abort, instr_in, exec_done, z_flag,
    output instr_addr, ir, ir_valid, pc, busy, halted, err, instr_count
  );
  modport slave (
    output start, abort, instr_in, exec_done, z_flag,
    input instr_addr, ir, ir_valid, pc, busy, halted, err, instr_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch/load/decode/execute control FSM with conditional jumps and bounds checking.
module fetch_sequencer #(
  parameter int PROG_LEN = 166,
  parameter logic [5:0] OP_NOP = 6'd46,
  parameter logic [5:0] OP_JUMPNZ = 6'd47,
  parameter logic [5:0] OP_JUMPZ = 6'd52
) (
  input logic clk,
  input logic rst_n,
  fetch_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, DECODE, EXEC, HALT} state_t;
  localparam logic [9:0] LEN = 10'(PROG_LEN);
  state_t state, state_n;
  logic [8:0] pc, pc_n;
  logic [15:0] ir, ir_n, cnt, cnt_n, cnt_inc;
  logic err, err_n, adv, jump, taken, bad_tgt;
  logic [9:0] pc_inc;
  logic [5:0] op;
  assign op = ir[15:10];
  assign pc_inc = {1'b0, pc} + 10'd1;
  assign cnt_inc = &cnt ? cnt : cnt + 16'd1;
  assign jump = op == OP_JUMPZ || op == OP_JUMPNZ;
  assign taken = (op == OP_JUMPZ && bus.z_flag) || (op == OP_JUMPNZ && !bus.z_flag);
  assign bad_tgt = ir[9] || {1'b0, ir[8:0]} >= LEN;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= '0;
      ir <= '0;
      err <= 1'b0;
      cnt <= '0;
    end else begin
      pc <= pc_n;
      ir <= ir_n;
      err <= err_n;
      cnt <= cnt_n;
    end
  always_comb begin
    state_n = state;
    pc_n = pc;
    ir_n = ir;
    err_n = err;
    cnt_n = cnt;
    adv = 1'b0;
    if (bus.abort) state_n = IDLE;
    else
      case (state)
        IDLE, HALT:
          if (bus.start) begin
            state_n = FETCH;
            pc_n = '0;
            cnt_n = '0;
            err_n = 1'b0;
          end
        FETCH: state_n = LOAD;
        LOAD: begin
          ir_n = bus.instr_in;
          state_n = DECODE;
        end
        DECODE:
          if (op == OP_NOP) state_n = HALT;
          else if (jump && taken && bad_tgt) begin
            err_n = 1'b1;
            state_n = HALT;
          end else if (jump && taken) begin
            pc_n = ir[8:0];
            cnt_n = cnt_inc;
            state_n = FETCH;
          end else if (jump) adv = 1'b1;
          else state_n = EXEC;
        EXEC: adv = bus.exec_done;
        default: state_n = IDLE;
      endcase
    // sequential advance past the last legal word is an error, not a retire
    if (adv) begin
      if (pc_inc >= LEN) begin
        err_n = 1'b1;
        state_n = HALT;
      end else begin
        pc_n = pc_inc[8:0];
        cnt_n = cnt_inc;
        state_n = FETCH;
      end
    end
  end
  assign bus.instr_addr = pc;
  assign bus.pc = pc;
  assign bus.ir = ir;
  assign bus.ir_valid = state == EXEC;
  assign bus.busy = state != IDLE && state != HALT;
  assign bus.halted = state == HALT;
  assign bus.err = err;
  assign bus.instr_count = cnt;
endmodule
